// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and FSM state encoding for the PWM decoder
package pwm_pkg;

    localparam int CNT_W_DEF   = 12;
    localparam int LEVEL_W_DEF = 3;
    localparam int MAX_CNT     = (1 << CNT_W_DEF) - 1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SYNC = 2'd1;
    localparam state_t ST_HIGH = 2'd2;
    localparam state_t ST_LOW  = 2'd3;

endpackage

// File: rtl/pwm_edge_sync.sv
// rtl/pwm_edge_sync.sv - two-flop synchronizer plus edge register for the PWM line
module pwm_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync_q;
    logic sync_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= pwm_in;
            sync_q <= meta;
            sync_d <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~sync_d;
    assign fall  = ~sync_q & sync_d;

endmodule

// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - measures PWM period and high time and quantizes duty to a speed level
module pwm_decoder #(
    parameter int CNT_W   = pwm_pkg::CNT_W_DEF,
    parameter int LEVEL_W = pwm_pkg::LEVEL_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               pwm_in,
    output logic [LEVEL_W-1:0] speed,
    output logic [CNT_W-1:0]   period,
    output logic [CNT_W-1:0]   high_time,
    output logic               valid,
    output logic               timeout
);
    import pwm_pkg::*;

    localparam int QW = CNT_W + 3;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic line;
    logic rise;
    logic fall;

    pwm_edge_sync u_edge_sync (
        .clock  (clock),
        .reset  (reset),
        .pwm_in (pwm_in),
        .level  (line),
        .rise   (rise),
        .fall   (fall)
    );

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_cnt;

    // Duty quantizer: level = number of k in 1..7 with 8*hi_cnt >= k*cnt.
    logic [QW-1:0]      hi_x8;
    logic [QW-1:0]      mult [1:7];
    logic [LEVEL_W-1:0] duty_level;

    always_comb begin
        hi_x8   = {hi_cnt, 3'b000};
        mult[1] = {3'b000, cnt};
        mult[2] = mult[1] << 1;
        mult[4] = mult[1] << 2;
        mult[3] = mult[2] + mult[1];
        mult[5] = mult[4] + mult[1];
        mult[6] = mult[4] + mult[2];
        mult[7] = mult[4] + mult[2] + mult[1];
        duty_level = '0;
        for (int k = 1; k <= 7; k++) begin
            if (hi_x8 >= mult[k]) begin
                duty_level = LEVEL_W'(k);
            end
        end
    end

    // A rise that is acted on takes priority over a counter expiry in the same cycle.
    logic rise_taken;
    logic expire;

    always_comb begin
        rise_taken = rise && (state == ST_SYNC || state == ST_LOW);
        expire     = (state != ST_IDLE) && (cnt == CNT_MAX) && !rise_taken;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            hi_cnt    <= '0;
            speed     <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else if (!enable) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hi_cnt <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (expire) begin
                timeout <= 1'b1;
                speed   <= line ? {LEVEL_W{1'b1}} : '0;
                cnt     <= '0;
                state   <= ST_SYNC;
            end else begin
                case (state)
                    ST_IDLE: begin
                        cnt   <= '0;
                        state <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        if (rise) begin
                            cnt   <= CNT_W'(1);
                            state <= ST_HIGH;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        cnt <= cnt + 1'b1;
                        if (fall) begin
                            hi_cnt <= cnt;
                            state  <= ST_LOW;
                        end
                    end
                    ST_LOW: begin
                        if (rise) begin
                            period    <= cnt;
                            high_time <= hi_cnt;
                            speed     <= duty_level;
                            valid     <= 1'b1;
                            timeout   <= 1'b0;
                            cnt       <= CNT_W'(1);
                            state     <= ST_HIGH;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// tb/tb_pwm_decoder.sv - self-checking bench for pwm_decoder
module tb_pwm_decoder;
    import pwm_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       pwm_in;
    logic [2:0] speed;
    logic [11:0] period;
    logic [11:0] high_time;
    logic       valid;
    logic       timeout;

    pwm_decoder #(.CNT_W(12), .LEVEL_W(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .pwm_in    (pwm_in),
        .speed     (speed),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        int cyc;
        int per;
        int hi;
        int spd;
        int to;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  rise_q[$];
    int  fall_q[$];
    bit  fresh_q[$];
    bit  fresh;
    int  checks = 0;
    int  errors = 0;

    always @(negedge clock) begin
        if (valid === 1'b1)
            obs_q.push_back('{cyc, int'(period), int'(high_time), int'(speed), int'(timeout)});
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic gen_period(input int p, input int h);
        pwm_in = 1'b1;
        rise_q.push_back(cyc);
        fresh_q.push_back(fresh);
        fresh = 1'b0;
        tick(h);
        pwm_in = 1'b0;
        fall_q.push_back(cyc);
        tick(p - h);
    endtask

    // Every rise after a non-restarted rise reports the previous rise-to-rise
    // interval, that rise's high time and floor(8*high/period) capped at 7,
    // three cycles after the rise on the pin.
    task automatic build_model();
        exp_q.delete();
        for (int i = 1; i < rise_q.size(); i++) begin
            if (!fresh_q[i]) begin
                int per, hi, spd;
                per = rise_q[i] - rise_q[i-1];
                hi  = fall_q[i-1] - rise_q[i-1];
                spd = (8 * hi) / per;
                if (spd > 7) spd = 7;
                exp_q.push_back('{rise_q[i] + 3, per, hi, spd, 0});
            end
        end
    endtask

    task automatic new_scenario();
        obs_q.delete();
        rise_q.delete();
        fall_q.delete();
        fresh_q.delete();
        fresh  = 1'b1;
        enable = 1'b0;
        pwm_in = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(6);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        pwm_in = 1'b0;
        tick(3);
        reset = 1'b0;
        checks++;
        if ({speed, period, high_time, valid, timeout} !== 29'd0) begin
            errors++;
            $display("FAIL reset_state got spd=%0d per=%0d hi=%0d v=%b to=%b want all 0",
                     speed, period, high_time, valid, timeout);
        end
    endtask

    task automatic test_measure();
        new_scenario();
        repeat (4) gen_period(80, 30);
        repeat (3) gen_period(64, 63);
        repeat (3) gen_period(64, 1);
        repeat (40) begin
            int p, h;
            p = $urandom_range(150, 2);
            h = $urandom_range(p - 1, 1);
            gen_period(p, h);
        end
        tick(6);
        build_model();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL measure_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL measure_ev%0d got cyc/per/hi/spd/to=%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                         i, obs_q[i].cyc, obs_q[i].per, obs_q[i].hi, obs_q[i].spd, obs_q[i].to,
                         exp_q[i].cyc, exp_q[i].per, exp_q[i].hi, exp_q[i].spd, exp_q[i].to);
            end
        end
    endtask

    task automatic test_timeout_low();
        int r;
        new_scenario();
        repeat (3) gen_period(80, 30);
        r = rise_q[rise_q.size() - 1];
        while (cyc < r + MAX_CNT - 1) tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL tlow_early got timeout=%b want 0", timeout);
        end
        while (cyc < r + MAX_CNT + 5) tick();
        checks++;
        if ({timeout, speed, period, high_time} !== {1'b1, 3'd0, 12'd80, 12'd30}) begin
            errors++;
            $display("FAIL tlow_flag got to=%b spd=%0d per=%0d hi=%0d want 1/0/80/30",
                     timeout, speed, period, high_time);
        end
        while (cyc < r + 5000) tick();
        fresh = 1'b1;
        repeat (4) gen_period(40, 20);
        tick(6);
        build_model();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL tlow_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL tlow_ev%0d got cyc/per/hi/spd/to=%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                         i, obs_q[i].cyc, obs_q[i].per, obs_q[i].hi, obs_q[i].spd, obs_q[i].to,
                         exp_q[i].cyc, exp_q[i].per, exp_q[i].hi, exp_q[i].spd, exp_q[i].to);
            end
        end
    endtask

    task automatic test_timeout_high();
        int r;
        new_scenario();
        repeat (3) gen_period(40, 20);
        pwm_in = 1'b1;
        r = cyc;
        rise_q.push_back(r);
        fresh_q.push_back(1'b0);
        while (cyc < r + MAX_CNT - 1) tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL thigh_early got timeout=%b want 0", timeout);
        end
        while (cyc < r + MAX_CNT + 5) tick();
        checks++;
        if ({timeout, speed, period, high_time} !== {1'b1, 3'd7, 12'd40, 12'd20}) begin
            errors++;
            $display("FAIL thigh_flag got to=%b spd=%0d per=%0d hi=%0d want 1/7/40/20",
                     timeout, speed, period, high_time);
        end
        while (cyc < r + 5000) tick();
        pwm_in = 1'b0;
        fall_q.push_back(cyc);
        tick(6);
        build_model();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL thigh_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL thigh_ev%0d got cyc/per/hi/spd/to=%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                         i, obs_q[i].cyc, obs_q[i].per, obs_q[i].hi, obs_q[i].spd, obs_q[i].to,
                         exp_q[i].cyc, exp_q[i].per, exp_q[i].hi, exp_q[i].spd, exp_q[i].to);
            end
        end
    endtask

    task automatic test_reset_mid();
        new_scenario();
        repeat (2) gen_period(80, 30);
        pwm_in = 1'b1;
        tick(10);
        reset  = 1'b1;
        pwm_in = 1'b0;
        tick(1);
        reset = 1'b0;
        checks++;
        if ({speed, period, high_time, valid, timeout} !== 29'd0) begin
            errors++;
            $display("FAIL rstmid_state got spd=%0d per=%0d hi=%0d v=%b to=%b want all 0",
                     speed, period, high_time, valid, timeout);
        end
        obs_q.delete();
        rise_q.delete();
        fall_q.delete();
        fresh_q.delete();
        fresh = 1'b1;
        tick(4);
        repeat (3) gen_period(80, 30);
        tick(6);
        build_model();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rstmid_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rstmid_ev%0d got cyc/per/hi/spd/to=%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                         i, obs_q[i].cyc, obs_q[i].per, obs_q[i].hi, obs_q[i].spd, obs_q[i].to,
                         exp_q[i].cyc, exp_q[i].per, exp_q[i].hi, exp_q[i].spd, exp_q[i].to);
            end
        end
    endtask

    task automatic test_enable_drop();
        new_scenario();
        repeat (3) gen_period(80, 30);
        enable = 1'b0;
        tick(20);
        checks++;
        if ({speed, period, high_time, valid} !== {3'd3, 12'd80, 12'd30, 1'b0}) begin
            errors++;
            $display("FAIL en_hold got spd=%0d per=%0d hi=%0d v=%b want 3/80/30/0",
                     speed, period, high_time, valid);
        end
        enable = 1'b1;
        fresh  = 1'b1;
        tick(4);
        repeat (3) gen_period(80, 30);
        tick(6);
        build_model();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL en_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL en_ev%0d got cyc/per/hi/spd/to=%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                         i, obs_q[i].cyc, obs_q[i].per, obs_q[i].hi, obs_q[i].spd, obs_q[i].to,
                         exp_q[i].cyc, exp_q[i].per, exp_q[i].hi, exp_q[i].spd, exp_q[i].to);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        pwm_in = 1'b0;
        fresh  = 1'b1;
        test_reset();
        test_measure();
        test_timeout_low();
        test_timeout_high();
        test_reset_mid();
        test_enable_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 Parameter CNT_W, default 12: width of the period and high-time counters and outputs.
REQ-002 Parameter LEVEL_W, default 3: width of the decoded speed level, matching the PWM encoder speed input.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  decoder runs when 1; when 0 it holds outputs and parks in IDLE.
REQ-006 pwm_in  input  1  asynchronous PWM line from the encoder or a pad.
REQ-007 speed  output  LEVEL_W  decoded duty level 0..7, registered.
REQ-008 period  output  CNT_W  last measured period in clock cycles, registered.
REQ-009 high_time  output  CNT_W  last measured high time in clock cycles, registered.
REQ-010 valid  output  1  one-cycle pulse when speed, period and high_time update.
REQ-011 timeout  output  1  sticky flag: no edge seen within 2^CNT_W-1 cycles; cleared by the next valid.

Function
REQ-012 pwm_in SHALL pass through a 2-flop synchronizer, then a third register for edge detection: rise = s & ~s_d, fall = ~s & s_d.
REQ-013 FSM states SHALL be IDLE, SYNC, HIGH and LOW.
REQ-014 IDLE -> SYNC when enable=1. Any state -> IDLE when enable=0, with counters cleared and outputs held.
REQ-015 SYNC SHALL discard everything until the first rise, then go to HIGH with cnt=1. No measurement is produced from a partial first period.
REQ-016 HIGH: cnt increments each cycle. On fall, latch hi_cnt=cnt and go to LOW.
REQ-017 LOW: cnt increments each cycle. On rise: period<=cnt, high_time<=hi_cnt, speed<=level, valid=1 for one cycle, cnt<=1, go to HIGH.
REQ-018 The measured period SHALL equal the number of clock cycles between consecutive detected rises. high_time SHALL equal the number of cycles from a rise to the following fall.
REQ-019 level SHALL be floor(8*hi_cnt/cnt), saturated to 7.
  - Compute with 7 parallel compares: {hi_cnt,3'b000} >= k*cnt for k=1..7.
  - k*cnt is built from shifts and adds at CNT_W+3 bits; no divider.
REQ-020 Outputs update in the same cycle valid is high. Total latency from the pwm_in rising edge to valid is 3 clock cycles (synchronizer plus edge register).
REQ-021 Timeout: if cnt reaches 2^CNT_W-1 in SYNC, HIGH or LOW:
  - timeout<=1, go to SYNC, counter does not wrap.
  - speed<=7 if the synchronized line is high, else speed<=0.
  - period and high_time are held.
REQ-022 A rise and a timeout in the same cycle SHALL be resolved as the rise; timeout is not set.
REQ-023 Glitch of one cycle (rise then fall next cycle) SHALL be measured as high_time=1, with no filtering.
REQ-024 0% or 100% duty SHALL be reported only through the timeout path of REQ-021.

Reset
REQ-025 On reset=1 at a clock edge: FSM=IDLE, all counters and synchronizer flops=0, speed=0, period=0, high_time=0, valid=0, timeout=0.
REQ-026 Reset asserted mid-measurement SHALL abandon the measurement with no valid pulse. After release, the next valid requires a fresh SYNC.

Structure
REQ-027 A shared package pwm_pkg SHALL hold the FSM state enum, the LEVEL_W and CNT_W defaults, and the MAX_CNT constant.
REQ-028 The synchronizer plus edge detector SHALL be one sub-module, pwm_edge_sync (outputs level, rise, fall). The FSM, counters and quantizer stay in pwm_decoder.

Verification
REQ-029 Steady PWM, period 80 cycles, high 30, enable=1:
  - From the second rise on: period=80, high_time=30, speed=3.
  - valid pulses once per 80 cycles, 3 cycles after each rise.
REQ-030 Period 64, high 63 -> speed=7. Period 64, high 1 -> speed=0, high_time=1.
REQ-031 pwm_in held low for 5000 cycles after a valid period:
  - timeout=1, speed=0 at cycle 4095 of the count.
  - A resumed PWM with period 40 / high 20 then gives valid, speed=4, timeout=0.
REQ-032 pwm_in held high for 5000 cycles -> timeout=1, speed=7, period and high_time unchanged.
REQ-033 Reset pulsed during HIGH -> all outputs 0 next cycle. No valid until one full period after the first post-reset rise.
REQ-034 enable dropped mid-LOW -> no valid, outputs hold. Re-enable -> first valid after SYNC plus one full period.
